// File: rtl/cpu_ctrl_pkg.sv
// Shared control-unit definitions: sequencer state encoding, opcode constants
// and the datapath strobe set used by every Mini SRC sequencer.
package cpu_ctrl_pkg;

  localparam logic [4:0] BR_OPCODE_DEF = 5'b10010;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T1W  = 4'd3,
    ST_T2   = 4'd4,
    ST_T3   = 4'd5,
    ST_T4   = 4'd6,
    ST_T5   = 4'd7,
    ST_T6   = 4'd8,
    ST_DONE = 4'd9
  } seq_state_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic z_in;
    logic zlow_out;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic gra;
    logic r_out;
    logic con_in;
    logic y_in;
    logic c_out;
    logic alu_add;
  } strobe_t;

endpackage

// File: rtl/wait_counter.sv
// Saturating memory-wait counter; tc_o flags the cycle in which one more
// enabled count would reach LIMIT.
module wait_counter #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clock,
  input  logic clear,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned W = $clog2(LIMIT + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i && (count_q != W'(LIMIT)))
      count_d = count_q + W'(1);
  end

  always_ff @(posedge clock) begin
    if (!clear) count_q <= '0;
    else        count_q <= count_d;
  end

  assign tc_o = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/branch_sequencer.sv
// Fetch-and-execute sequencer for one Mini SRC conditional branch; drives the
// datapath strobes and reports taken/illegal/timeout status to the control unit.
module branch_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter logic [4:0]  BR_OPCODE      = BR_OPCODE_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clock,
  input  logic       clear,
  input  logic       start,
  input  logic       mem_ready,
  input  logic [4:0] ir_opcode,
  input  logic       con_in,
  output logic       PCout,
  output logic       MARin,
  output logic       IncPC,
  output logic       Zin,
  output logic       Zlowout,
  output logic       PCin,
  output logic       Read,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Gra,
  output logic       Rout,
  output logic       CONin,
  output logic       Yin,
  output logic       Cout,
  output logic       alu_add,
  output logic       busy,
  output logic       done,
  output logic       taken,
  output logic       illegal,
  output logic       timeout,
  output logic [3:0] step
);

  seq_state_e state_q, state_d;
  logic       con_q, con_d;
  logic       taken_q, taken_d;
  logic       illegal_q, illegal_d;
  logic       timeout_q, timeout_d;
  logic       wait_tc;
  strobe_t    s;

  wait_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wait (
    .clock (clock),
    .clear (clear),
    .clr_i (state_q == ST_T1),
    .en_i  ((state_q == ST_T1W) && !mem_ready),
    .tc_o  (wait_tc)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      state_q   <= ST_IDLE;
      con_q     <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      con_q     <= con_d;
      taken_q   <= taken_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    con_d     = con_q;
    taken_d   = taken_q;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    s         = '0;
    unique case (state_q)
      ST_IDLE: if (start) begin
        state_d   = ST_T0;
        con_d     = 1'b0;
        taken_d   = 1'b0;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
      end
      ST_T0: begin
        s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1;
        state_d  = ST_T1;
      end
      ST_T1: begin
        s.zlow_out = 1'b1; s.pc_in = 1'b1;
        state_d    = ST_T1W;
      end
      // mem_ready wins over the terminal count in the last allowed wait cycle
      ST_T1W: begin
        s.read = 1'b1; s.mdr_in = 1'b1;
        if (mem_ready) begin
          state_d = ST_T2;
        end else if (wait_tc) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end
      end
      ST_T2: begin
        s.mdr_out = 1'b1; s.ir_in = 1'b1;
        state_d   = ST_T3;
      end
      ST_T3: begin
        if (ir_opcode != BR_OPCODE) begin
          illegal_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          s.gra = 1'b1; s.r_out = 1'b1; s.con_in = 1'b1;
          con_d   = con_in;
          state_d = ST_T4;
        end
      end
      ST_T4: begin
        s.pc_out = 1'b1; s.y_in = 1'b1;
        state_d  = ST_T5;
      end
      ST_T5: begin
        s.c_out = 1'b1; s.alu_add = 1'b1; s.z_in = 1'b1;
        state_d = ST_T6;
      end
      ST_T6: begin
        s.zlow_out = 1'b1; s.pc_in = con_q;
        taken_d    = con_q;
        state_d    = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign PCout   = s.pc_out;
  assign MARin   = s.mar_in;
  assign IncPC   = s.inc_pc;
  assign Zin     = s.z_in;
  assign Zlowout = s.zlow_out;
  assign PCin    = s.pc_in;
  assign Read    = s.read;
  assign MDRin   = s.mdr_in;
  assign MDRout  = s.mdr_out;
  assign IRin    = s.ir_in;
  assign Gra     = s.gra;
  assign Rout    = s.r_out;
  assign CONin   = s.con_in;
  assign Yin     = s.y_in;
  assign Cout    = s.c_out;
  assign alu_add = s.alu_add;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);
  assign taken   = taken_q;
  assign illegal = illegal_q;
  assign timeout = timeout_q;
  assign step    = state_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: expected outcomes are queued at start and
// checked against the DUT when done is observed.
module tb_branch_sequencer;

  localparam logic [4:0] BR  = 5'b10010;
  localparam logic [4:0] BAD = 5'b00011;
  localparam int         TO  = 16;

  logic clock = 1'b0, clear = 1'b0, start = 1'b0, mem_ready = 1'b0, con_in = 1'b0;
  logic [4:0] ir_opcode = 5'b0;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin;
  logic Gra, Rout, CONin, Yin, Cout, alu_add, busy, done, taken, illegal, timeout;
  logic [3:0] step;
  logic [15:0] strb;
  logic [24:0] all_out;

  always #5 clock = ~clock;

  branch_sequencer #(.BR_OPCODE(BR), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready),
    .ir_opcode(ir_opcode), .con_in(con_in),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin), .Zlowout(Zlowout),
    .PCin(PCin), .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Gra(Gra), .Rout(Rout), .CONin(CONin), .Yin(Yin), .Cout(Cout), .alu_add(alu_add),
    .busy(busy), .done(done), .taken(taken), .illegal(illegal), .timeout(timeout),
    .step(step)
  );

  assign strb    = {PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin,
                    MDRout, IRin, Gra, Rout, CONin, Yin, Cout, alu_add};
  assign all_out = {strb, busy, done, taken, illegal, timeout, step};

  typedef struct {
    int lat;
    bit tk, il, to;
    int pcin, irin, conin, pcout;
  } exp_t;

  exp_t sbq[$];
  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // d = cycles mem_ready stays low in T1W; d >= TO means it never rises in time.
  task automatic run_op(input logic [4:0] op, input int d, input bit con_t3, input bit con_oth);
    exp_t e, got_e;
    int   pcin = 0, irin = 0, conin = 0, pcout = 0;
    bit   got = 1'b0;
    int   lat = 0;
    if (d >= TO) begin
      e = '{lat: 3 + TO, tk: 0, il: 0, to: 1, pcin: 1, irin: 0, conin: 0, pcout: 1};
    end else if (op != BR) begin
      e = '{lat: 6 + d, tk: 0, il: 1, to: 0, pcin: 1, irin: 1, conin: 0, pcout: 1};
    end else begin
      e = '{lat: 9 + d, tk: con_t3, il: 0, to: 0, pcin: 1 + int'(con_t3),
            irin: 1, conin: 1, pcout: 2};
    end
    sbq.push_back(e);
    ir_opcode = op;
    @(negedge clock);
    start = 1'b1; mem_ready = 1'b0; con_in = con_oth;
    @(posedge clock);
    for (int n = 1; n <= 40 && !got; n++) begin
      @(negedge clock);
      start     = 1'b0;
      con_in    = (n == 5 + d) ? con_t3 : con_oth;
      mem_ready = (n >= 3 + d);
      pcin  += int'(PCin);
      irin  += int'(IRin);
      conin += int'(CONin);
      pcout += int'(PCout);
      if (done === 1'b1) begin
        got = 1'b1;
        lat = n;
      end
    end
    chk("done_seen", {31'b0, got}, 32'd1);
    got_e = sbq.pop_front();
    if (got) begin
      chk("latency",   lat,   got_e.lat);
      chk("taken",     {31'b0, taken},   {31'b0, got_e.tk});
      chk("illegal",   {31'b0, illegal}, {31'b0, got_e.il});
      chk("timeout",   {31'b0, timeout}, {31'b0, got_e.to});
      chk("pcin_cnt",  pcin,  got_e.pcin);
      chk("irin_cnt",  irin,  got_e.irin);
      chk("conin_cnt", conin, got_e.conin);
      chk("pcout_cnt", pcout, got_e.pcout);
      @(negedge clock);
      mem_ready = 1'b0;
      chk("idle_busy",  {31'b0, busy},  32'd0);
      chk("idle_done",  {31'b0, done},  32'd0);
      chk("held_flags", {29'b0, taken, illegal, timeout}, {29'b0, got_e.tk, got_e.il, got_e.to});
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {7'b0, all_out}, 32'd0);
    clear = 1'b1;

    run_op(BR, 0, 1'b1, 1'b0);
    run_op(BR, 0, 1'b0, 1'b1);
    run_op(BR, 3, 1'b1, 1'b0);
    run_op(BR, TO - 1, 1'b1, 1'b1);
    run_op(BR, 1000, 1'b1, 1'b1);
    run_op(BAD, 0, 1'b1, 1'b1);

    // Mid-operation reset with a stray start pulsed while busy
    ir_opcode = BR;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clock);
      start     = (n == 2);
      mem_ready = 1'b1;
      con_in    = 1'b1;
    end
    chk("t4_pcout_yin", {30'b0, PCout, Yin}, 32'd3);
    clear = 1'b0;
    @(negedge clock);
    chk("abort_outputs", {7'b0, all_out}, 32'd0);
    clear = 1'b1;
    mem_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clock);
      chk("abort_stays_idle", {31'b0, busy}, 32'd0);
    end

    run_op(BR, 0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Control-unit sequencer that fetches and executes one conditional branch instruction (brzr/brnz/brpl/brmi) on the Mini SRC datapath. It drives the datapath register-enable and bus-select strobes through the fetch and branch steps. During the condition step it latches the result produced by the condition-evaluation logic, and it loads the branch target into PC only when that condition is true. It sits between the top-level control unit (start/done handshake) and the datapath.

## Interface
- BR_OPCODE, 5'b10010, IR[31:27] value identifying a branch instruction
- TIMEOUT_CYCLES, 16, max cycles to wait for mem_ready before aborting (≥2)
- clock  in  1  system clock, all state updates on rising edge
- clear  in  1  reset, synchronous, active-low
- start  in  1  request to run one branch instruction; sampled only in IDLE
- mem_ready  in  1  memory read data valid on MDR input
- ir_opcode  in  5  IR[31:27] from IR register
- con_in  in  1  combinational branch-condition result (1 = condition met)
- PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, MDRin, MDRout, IRin, Gra, Rout, CONin, Yin, Cout, alu_add  out  1 each  datapath strobes
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- taken  out  1  branch was taken (valid from done, held until next accepted start)
- illegal  out  1  opcode was not BR_OPCODE (held likewise)
- timeout  out  1  memory wait exceeded TIMEOUT_CYCLES (held likewise)
- step  out  4  current state encoding, for debug

## Operation
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, DONE. Moore outputs are decoded from state only, except where noted.
- IDLE: all strobes 0. If start=1, clear taken/illegal/timeout/con_q and go to T0.
- T0: PCout, MARin, IncPC, Zin. Go to T1.
- T1: Zlowout, PCin. Reset the wait counter. Go to T1W.
- T1W: Read, MDRin. Increment the wait counter each cycle mem_ready=0.
  - mem_ready=1: go to T2.
  - Counter reaches TIMEOUT_CYCLES with mem_ready=0: set timeout and go to DONE.
- T2: MDRout, IRin. Go to T3.
- T3: decision is based on ir_opcode, which is valid here because IR was loaded at the end of T2.
  - ir_opcode≠BR_OPCODE: no strobes, set illegal, go to DONE.
  - Otherwise: Gra, Rout, CONin; register con_q←con_in at end of cycle; go to T4.
- T4: PCout, Yin. Go to T5.
- T5: Cout, alu_add, Zin. Go to T6.
- T6: Zlowout, and PCin=con_q. taken←con_q. Go to DONE.
- DONE: done=1, all strobes 0. Go to IDLE.
- start while busy=1 is ignored. It is not queued.
- clear=0 in any state, at the next edge: state IDLE, all outputs 0, counter 0, con_q 0. This applies mid-operation too. No partial strobe is emitted after reset.

## Timing
- Reset values: every output 0, step=IDLE encoding.
- start accepted on edge k → T0 during cycle k+1.
- mem_ready already high: T2 at k+4, done at k+9.
- Each cycle of mem_ready=0 in T1W adds one cycle of latency.
- Timeout path: done occurs exactly TIMEOUT_CYCLES cycles after T1W entry, plus 1.
- Illegal path: done at k+6.
- con_in is sampled only at the end of T3. Changes on con_in in any other cycle have no effect.
- Exactly one PCin cycle occurs in T1. A second PCin cycle occurs in T6 only if con_q=1.

## Structure
- Shared package (cpu_ctrl_pkg): state enum, BR_OPCODE constant, step encoding. The strobe-set type is shared with the other sequencers.
- One sub-module: wait_counter (saturating counter with clear, enable and terminal-count outputs), reused by the other memory-access sequencers.
- Remainder: one registered-state FSM plus a combinational output decode.

## Test plan
- Reset, then opcode 5'b10010, mem_ready=1, con_in=1 at T3 → done at k+9, PCin pulses in T1 and T6, taken=1.
- Same with con_in=0 at T3 and con_in=1 in all other cycles → PCin only in T1, taken=0.
- mem_ready low for 3 cycles then high → done at k+12, timeout=0.
- mem_ready never high, TIMEOUT_CYCLES=16 → timeout=1, done at k+19, no IRin pulse.
- ir_opcode=5'b00011 → illegal=1, no CONin/PCout after T2, done at k+6.
- Set clear=0 during T4, then start=1 pulsed during busy → outputs 0 next cycle, returns to IDLE, the extra start is ignored, and a fresh start runs normally.
